mem_arbiter: RTL and testbench

Two-master arbiter sharing the single CPU-side read/write port of the main 16K×16 data memory. The CPU (master 0) and a secondary bus master (master 1), such as the program/glyph loader, both need that port. The block issues at most one access per cycle, with round-robin fairness and an optional lock for atomic multi-access sequences. It sits between the masters and the memory wrapper and drives the memory's address, write-data and write-enable inputs. The pixel-clock glyph port is not touched.

---
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter, with an optional lock, for the
// CPU-side read/write port of the 16Kx16 data memory.
//   clk_i, rst_ni             clock; synchronous active-low reset
//   mN_req_i/we_i/lock_i      master N request, write select, hold ownership
//   mN_addr_i/wdata_i         master N word address and write data
//   mN_ack_o                  access accepted this cycle (combinational)
//   mN_rvalid_o/rdata_o       read data one cycle after a read ack (registered)
//   mem_addr_o/wdata_o/we_o   drive the memory port (combinational, 0 when idle)
//   mem_rdata_i               memory read data, stable at the rising edge
module mem_arbiter #(
    parameter int unsigned AW       = 14,
    parameter int unsigned DW       = 16,
    parameter int unsigned LOCK_MAX = 15
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          m0_req_i,
    input  logic          m0_we_i,
    input  logic          m0_lock_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_wdata_i,
    output logic          m0_ack_o,
    output logic          m0_rvalid_o,
    output logic [DW-1:0] m0_rdata_o,
    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic          m1_lock_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_wdata_i,
    output logic          m1_ack_o,
    output logic          m1_rvalid_o,
    output logic [DW-1:0] m1_rdata_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic          mem_we_o,
    input  logic [DW-1:0] mem_rdata_i
);

    localparam int unsigned LCW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic           last_q, last_d;
    logic [LCW-1:0] lcnt_q, lcnt_d;
    logic           m0_rvalid_q, m0_rvalid_d;
    logic           m1_rvalid_q, m1_rvalid_d;
    logic [DW-1:0]  m0_rdata_q, m0_rdata_d;
    logic [DW-1:0]  m1_rdata_q, m1_rdata_d;
    logic           sel0, sel1;
    logic           gnt0, gnt1;
    logic [AW-1:0]  addr_c;
    logic [DW-1:0]  wdata_c;
    logic           we_c;

    // State register and registered read return.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            lcnt_q      <= '0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            lcnt_q      <= lcnt_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
        end
    end

    // Winner selection, lock/timeout next state, and memory port mux.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        lcnt_d      = lcnt_q;
        sel0        = 1'b0;
        sel1        = 1'b0;
        addr_c      = '0;
        wdata_c     = '0;
        we_c        = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (m0_req_i && m1_req_i) begin
                    // Conflict: the master that was not granted last goes first.
                    sel0 = last_q;
                    sel1 = ~last_q;
                end else begin
                    sel0 = m0_req_i;
                    sel1 = m1_req_i;
                end
            end
            LOCK0:   sel0 = m0_req_i;
            LOCK1:   sel1 = m1_req_i;
            default: state_d = IDLE;
        endcase

        // Nothing is granted while reset is held.
        gnt0 = sel0 & rst_ni;
        gnt1 = sel1 & rst_ni;

        if (gnt0) begin
            last_d  = 1'b0;
            lcnt_d  = '0;
            state_d = m0_lock_i ? LOCK0 : IDLE;
            addr_c  = m0_addr_i;
            wdata_c = m0_wdata_i;
            we_c    = m0_we_i;
        end else if (gnt1) begin
            last_d  = 1'b1;
            lcnt_d  = '0;
            state_d = m1_lock_i ? LOCK1 : IDLE;
            addr_c  = m1_addr_i;
            wdata_c = m1_wdata_i;
            we_c    = m1_we_i;
        end else if (state_q != IDLE) begin
            // A locked state without a grant means the owner is idle.
            lcnt_d = lcnt_q + LCW'(1);
            if (lcnt_d == LCW'(LOCK_MAX)) begin
                state_d = IDLE;
                lcnt_d  = '0;
            end
        end

        m0_rvalid_d = gnt0 & ~m0_we_i;
        m1_rvalid_d = gnt1 & ~m1_we_i;
        if (m0_rvalid_d) m0_rdata_d = mem_rdata_i;
        if (m1_rvalid_d) m1_rdata_d = mem_rdata_i;
    end

    assign m0_ack_o    = gnt0;
    assign m1_ack_o    = gnt1;
    assign mem_addr_o  = addr_c;
    assign mem_wdata_o = wdata_c;
    assign mem_we_o    = we_c;
    assign m0_rvalid_o = m0_rvalid_q;
    assign m1_rvalid_o = m1_rvalid_q;
    assign m0_rdata_o  = m0_rdata_q;
    assign m1_rdata_o  = m1_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a falling-edge 16Kx16
// memory model behind the arbitrated port.
module tb_mem_arbiter;

    localparam int unsigned AW = 14;
    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req, m0_we, m0_lock;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_ack, m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m1_req, m1_we, m1_lock;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_ack, m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata = '0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(15)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_lock_i(m0_lock),
        .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_ack_o(m0_ack), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_lock_i(m1_lock),
        .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_ack_o(m1_ack), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory: write-first on the falling edge, read data held to the next fall.
    always @(negedge clk) begin
        if (mem_we) mem[mem_addr] = mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    // Bus hygiene, sampled mid-cycle.
    always @(negedge clk) begin
        checks++;
        if ((mem_we && !(m0_ack || m1_ack)) || (m0_ack && m1_ack)) begin
            errors++;
            $display("FAIL hygiene: we=%0b ack0=%0b ack1=%0b, required no we without ack and not both acks",
                     mem_we, m0_ack, m1_ack);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 14'h0100;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 14'h0200;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #1;
            checks++;
            if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 14'h0
                || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || m0_rdata !== 16'h0 || m1_rdata !== 16'h0) begin
                errors++;
                $display("FAIL reset_hold: ack0=%0b ack1=%0b we=%0b addr=%h rv0=%0b rv1=%0b, required all 0",
                         m0_ack, m1_ack, mem_we, mem_addr, m0_rvalid, m1_rvalid);
            end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (m0_ack !== 1'b1 || m1_ack !== 1'b0 || mem_addr !== 14'h0100) begin
            errors++;
            $display("FAIL reset_first_grant: ack0=%0b ack1=%0b addr=%h, required 1 0 0100", m0_ack, m1_ack, mem_addr);
        end
        next_cycle();
        m0_req = 1'b0;
        #1;
        checks++;
        if (m1_ack !== 1'b1 || m0_rvalid !== 1'b1 || mem_addr !== 14'h0200) begin
            errors++;
            $display("FAIL reset_second_grant: ack1=%0b rv0=%0b addr=%h, required 1 1 0200", m1_ack, m0_rvalid, mem_addr);
        end
        next_cycle();
        m1_req = 1'b0;
        #1;
        checks++;
        if (m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_rvalid: rv1=%0b rv0=%0b, required 1 0", m1_rvalid, m0_rvalid);
        end
    endtask

    task automatic test_read_latency();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 14'h0123; m0_wdata = 16'hBEEF;
        #1;
        checks++;
        if (m0_ack !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 16'hBEEF || mem_addr !== 14'h0123) begin
            errors++;
            $display("FAIL write_grant: ack0=%0b we=%0b wdata=%h addr=%h, required 1 1 beef 0123",
                     m0_ack, mem_we, mem_wdata, mem_addr);
        end
        next_cycle();
        m0_we = 1'b0;
        #1;
        checks++;
        if (m0_ack !== 1'b1 || mem_we !== 1'b0 || m0_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL read_grant: ack0=%0b we=%0b rv0=%0b, required 1 0 0", m0_ack, mem_we, m0_rvalid);
        end
        next_cycle();
        m0_req = 1'b0;
        #1;
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL read_data: rv0=%0b rdata=%h, required 1 beef", m0_rvalid, m0_rdata);
        end
        next_cycle();
        checks++;
        if (m0_rvalid !== 1'b0 || m0_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL read_pulse: rv0=%0b rdata=%h, required 0 beef (held)", m0_rvalid, m0_rdata);
        end
    endtask

    task automatic test_round_robin();
        logic exp0;
        logic [AW-1:0] exp_addr;
        // Single m1 write so m1 is the last granted master.
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 14'h0200; m1_wdata = 16'h5A5A;
        #1;
        checks++;
        if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin
            errors++;
            $display("FAIL rr_prelude: ack1=%0b ack0=%0b, required 1 0", m1_ack, m0_ack);
        end
        next_cycle();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 14'h0010;
        m1_we = 1'b0; m1_addr = 14'h0020;
        for (int i = 0; i < 6; i++) begin
            exp0 = (i % 2 == 0);
            exp_addr = exp0 ? AW'(14'h0010 + i / 2) : AW'(14'h0020 + i / 2);
            #1;
            checks++;
            if (m0_ack !== exp0 || m1_ack !== !exp0 || mem_addr !== exp_addr) begin
                errors++;
                $display("FAIL rr_cycle%0d: ack0=%0b ack1=%0b addr=%h, required %0b %0b %h",
                         i, m0_ack, m1_ack, mem_addr, exp0, !exp0, exp_addr);
            end
            next_cycle();
            if (exp0) m0_addr = m0_addr + AW'(1);
            else      m1_addr = m1_addr + AW'(1);
        end
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    task automatic test_lock();
        // Single m0 read so m0 is the last granted master.
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 14'h0300;
        next_cycle();
        m0_addr = 14'h0400;
        m1_req = 1'b1; m1_we = 1'b1; m1_lock = 1'b1; m1_addr = 14'h0010; m1_wdata = 16'h1234;
        #1;
        checks++;
        if (m1_ack !== 1'b1 || m0_ack !== 1'b0 || mem_we !== 1'b1) begin
            errors++;
            $display("FAIL lock_write: ack1=%0b ack0=%0b we=%0b, required 1 0 1", m1_ack, m0_ack, mem_we);
        end
        next_cycle();
        m1_we = 1'b0;
        #1;
        checks++;
        if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin
            errors++;
            $display("FAIL lock_read: ack1=%0b ack0=%0b, required 1 0", m1_ack, m0_ack);
        end
        next_cycle();
        m1_we = 1'b1; m1_lock = 1'b0; m1_addr = 14'h0011; m1_wdata = 16'h4321;
        #1;
        checks++;
        if (m1_ack !== 1'b1 || m0_ack !== 1'b0 || m1_rvalid !== 1'b1 || m1_rdata !== 16'h1234) begin
            errors++;
            $display("FAIL lock_release: ack1=%0b ack0=%0b rv1=%0b rdata=%h, required 1 0 1 1234",
                     m1_ack, m0_ack, m1_rvalid, m1_rdata);
        end
        next_cycle();
        m1_req = 1'b0; m1_we = 1'b0;
        #1;
        checks++;
        if (m0_ack !== 1'b1 || mem_addr !== 14'h0400) begin
            errors++;
            $display("FAIL lock_after: ack0=%0b addr=%h, required 1 0400", m0_ack, mem_addr);
        end
        next_cycle();
        m0_req = 1'b0;
    endtask

    task automatic test_timeout();
        m0_req = 1'b1; m0_we = 1'b0; m0_lock = 1'b1; m0_addr = 14'h0123;
        #1;
        checks++;
        if (m0_ack !== 1'b1) begin
            errors++;
            $display("FAIL timeout_lock: ack0=%0b, required 1", m0_ack);
        end
        next_cycle();
        m0_req = 1'b0; m0_lock = 1'b0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 14'h0011;
        for (int i = 0; i < 15; i++) begin
            #1;
            checks++;
            if (m1_ack !== 1'b0) begin
                errors++;
                $display("FAIL timeout_hold%0d: ack1=%0b, required 0", i, m1_ack);
            end
            next_cycle();
        end
        #1;
        checks++;
        if (m1_ack !== 1'b1 || mem_addr !== 14'h0011) begin
            errors++;
            $display("FAIL timeout_grant: ack1=%0b addr=%h, required 1 0011", m1_ack, mem_addr);
        end
        next_cycle();
        m1_req = 1'b0;
        checks++;
        if (m1_rvalid !== 1'b1 || m1_rdata !== 16'h4321) begin
            errors++;
            $display("FAIL timeout_data: rv1=%0b rdata=%h, required 1 4321", m1_rvalid, m1_rdata);
        end
    endtask

    task automatic test_reset_mid_lock();
        m1_req = 1'b1; m1_we = 1'b0; m1_lock = 1'b1; m1_addr = 14'h0010;
        #1;
        checks++;
        if (m1_ack !== 1'b1) begin
            errors++;
            $display("FAIL midlock_enter: ack1=%0b, required 1", m1_ack);
        end
        next_cycle();
        m1_req = 1'b0; m1_lock = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 14'h0123;
        rst_n = 1'b0;
        #1;
        checks++;
        if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL midlock_gated: ack0=%0b ack1=%0b we=%0b, required 0 0 0", m0_ack, m1_ack, mem_we);
        end
        next_cycle();
        rst_n = 1'b1;
        #1;
        checks++;
        if (m0_ack !== 1'b1 || m1_rvalid !== 1'b0 || m1_rdata !== 16'h0) begin
            errors++;
            $display("FAIL midlock_release: ack0=%0b rv1=%0b rdata1=%h, required 1 0 0000",
                     m0_ack, m1_rvalid, m1_rdata);
        end
        next_cycle();
        m0_req = 1'b0;
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL midlock_read: rv0=%0b rdata=%h, required 1 beef", m0_rvalid, m0_rdata);
        end
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
        rst_n = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = '0; m1_wdata = '0;
        test_reset();
        test_read_latency();
        test_round_robin();
        test_lock();
        test_timeout();
        test_reset_mid_lock();
        next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
